// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared state, select encodings and instruction classes for the CPU controller
package cpu_pkg;

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_WRITE_IMM = 3'd2,
        S_GET_A     = 3'd3,
        S_GET_B     = 3'd4,
        S_EXEC      = 3'd5,
        S_WRITE_REG = 3'd6
    } state_t;

    // One-hot register-field selects handed to the instruction decoder
    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_M    = 3'b001;
    localparam logic [2:0] NSEL_D    = 3'b010;
    localparam logic [2:0] NSEL_N    = 3'b100;

    // Writeback source selects
    localparam logic [1:0] VSEL_C    = 2'b00;
    localparam logic [1:0] VSEL_IMM  = 2'b01;

    // Instruction classes as {opcode, op}
    localparam logic [4:0] INS_MOV_IMM = 5'b110_10;
    localparam logic [4:0] INS_MOV_REG = 5'b110_00;
    localparam logic [4:0] INS_ADD     = 5'b101_00;
    localparam logic [4:0] INS_CMP     = 5'b101_01;
    localparam logic [4:0] INS_AND     = 5'b101_10;
    localparam logic [4:0] INS_MVN     = 5'b101_11;

    // Moves and MVN have no A operand, so the ALU sees zero on that side
    function automatic logic is_single_operand(input logic [4:0] ins);
        return (ins == INS_MOV_REG) || (ins == INS_MVN);
    endfunction

endpackage

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - Moore FSM sequencing register reads, ALU execute and writeback
module cpu_controller
    import cpu_pkg::*;
#(
    parameter logic [2:0] NSEL_RM = NSEL_M,
    parameter logic [2:0] NSEL_RD = NSEL_D,
    parameter logic [2:0] NSEL_RN = NSEL_N
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       w,
    output logic [2:0] nsel,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic [1:0] vsel,
    output logic       write
);

    state_t     r_state;
    state_t     w_next;
    logic [4:0] r_ins;

    // State register; reset drops straight back to idle, aborting any instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_WAIT;
        end else begin
            r_state <= w_next;
        end
    end

    // Capture the instruction class while leaving DECODE so later states ignore decoder changes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ins <= 5'b000_00;
        end else if (r_state == S_DECODE) begin
            r_ins <= {opcode, op};
        end
    end

    // Next-state and Moore output decode from the state and latched class
    always_comb begin
        w_next = S_WAIT;
        w      = 1'b0;
        nsel   = NSEL_NONE;
        loada  = 1'b0;
        loadb  = 1'b0;
        loadc  = 1'b0;
        loads  = 1'b0;
        asel   = 1'b0;
        bsel   = 1'b0;
        vsel   = VSEL_C;
        write  = 1'b0;
        case (r_state)
            S_WAIT: begin
                w      = 1'b1;
                w_next = s ? S_DECODE : S_WAIT;
            end
            S_DECODE: begin
                // Branch on the live decoder fields; they are latched on this same edge
                case ({opcode, op})
                    INS_MOV_IMM:                 w_next = S_WRITE_IMM;
                    INS_MOV_REG, INS_MVN:        w_next = S_GET_B;
                    INS_ADD, INS_CMP, INS_AND:   w_next = S_GET_A;
                    default:                     w_next = S_WAIT;
                endcase
            end
            S_WRITE_IMM: begin
                nsel   = NSEL_RN;
                vsel   = VSEL_IMM;
                write  = 1'b1;
                w_next = S_WAIT;
            end
            S_GET_A: begin
                nsel   = NSEL_RN;
                loada  = 1'b1;
                w_next = S_GET_B;
            end
            S_GET_B: begin
                nsel   = NSEL_RM;
                loadb  = 1'b1;
                w_next = S_EXEC;
            end
            S_EXEC: begin
                asel = is_single_operand(r_ins);
                if (r_ins == INS_CMP) begin
                    loads  = 1'b1;
                    w_next = S_WAIT;
                end else begin
                    loadc  = 1'b1;
                    w_next = S_WRITE_REG;
                end
            end
            S_WRITE_REG: begin
                nsel   = NSEL_RD;
                vsel   = VSEL_C;
                write  = 1'b1;
                w_next = S_WAIT;
            end
            default: begin
                w_next = S_WAIT;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - directed self-checking bench for cpu_controller
module tb_cpu_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       s;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       w;
    logic [2:0] nsel;
    logic       loada, loadb, loadc, loads, asel, bsel;
    logic [1:0] vsel;
    logic       write;

    int n_checks = 0;
    int n_pass   = 0;

    // Packed output view: {w, nsel[2:0], loada, loadb, loadc, loads, asel, bsel, vsel[1:0], write}
    localparam logic [12:0] O_WAIT     = 13'h1000;
    localparam logic [12:0] O_DEC      = 13'h0000;
    localparam logic [12:0] O_WIMM     = 13'h0803;
    localparam logic [12:0] O_GETA     = 13'h0900;
    localparam logic [12:0] O_GETB     = 13'h0280;
    localparam logic [12:0] O_EXEC_ALU = 13'h0040;
    localparam logic [12:0] O_EXEC_MOV = 13'h0050;
    localparam logic [12:0] O_EXEC_CMP = 13'h0020;
    localparam logic [12:0] O_WREG     = 13'h0401;

    cpu_controller dut (
        .clk    (clk),
        .reset  (reset),
        .s      (s),
        .opcode (opcode),
        .op     (op),
        .w      (w),
        .nsel   (nsel),
        .loada  (loada),
        .loadb  (loadb),
        .loadc  (loadc),
        .loads  (loads),
        .asel   (asel),
        .bsel   (bsel),
        .vsel   (vsel),
        .write  (write)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] outs();
        return {w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction with a one-cycle start pulse; returns one edge later, in DECODE
    task automatic launch(input logic [2:0] oc, input logic [1:0] o);
        opcode = oc;
        op     = o;
        s      = 1'b1;
        tick();
        s      = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; s = 1'b0; opcode = 3'b000; op = 2'b00;
        #2;
        n_checks++;
        if (outs() !== O_WAIT) $display("FAIL reset_async outputs=%h expected=%h", outs(), O_WAIT);
        else n_pass++;
        s = 1'b1;
        tick();
        n_checks++;
        if (outs() !== O_WAIT) $display("FAIL reset_held_s outputs=%h expected=%h", outs(), O_WAIT);
        else n_pass++;
        s = 1'b0;
        reset = 1'b0;
        tick();
        n_checks++;
        if (outs() !== O_WAIT) $display("FAIL reset_idle outputs=%h expected=%h", outs(), O_WAIT);
        else n_pass++;
    endtask

    task automatic test_mov_imm(input string name);
        logic [12:0] exp [2];
        exp = '{O_WIMM, O_WAIT};
        launch(3'b110, 2'b10);
        n_checks++;
        if (outs() !== O_DEC) $display("FAIL %s_decode outputs=%h expected=%h", name, outs(), O_DEC);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (outs() !== exp[i]) $display("FAIL %s_cycle%0d outputs=%h expected=%h", name, i + 2, outs(), exp[i]);
            else n_pass++;
        end
    endtask

    // ADD/AND: opcode is scrambled after DECODE to show the latched class drives the sequence
    task automatic test_alu(input string name, input logic [1:0] o);
        logic [12:0] exp [5];
        exp = '{O_GETA, O_GETB, O_EXEC_ALU, O_WREG, O_WAIT};
        launch(3'b101, o);
        n_checks++;
        if (outs() !== O_DEC) $display("FAIL %s_decode outputs=%h expected=%h", name, outs(), O_DEC);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) begin opcode = 3'b111; op = 2'b01; end
            n_checks++;
            if (outs() !== exp[i]) $display("FAIL %s_cycle%0d outputs=%h expected=%h", name, i + 2, outs(), exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_cmp();
        logic [12:0] exp [4];
        exp = '{O_GETA, O_GETB, O_EXEC_CMP, O_WAIT};
        launch(3'b101, 2'b01);
        n_checks++;
        if (outs() !== O_DEC) $display("FAIL cmp_decode outputs=%h expected=%h", outs(), O_DEC);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) begin opcode = 3'b101; op = 2'b00; end
            n_checks++;
            if (outs() !== exp[i]) $display("FAIL cmp_cycle%0d outputs=%h expected=%h", i + 2, outs(), exp[i]);
            else n_pass++;
        end
    endtask

    // MOV reg / MVN skip GET_A; decoder switches to MOV imm during GET_B
    task automatic test_single(input string name, input logic [2:0] oc, input logic [1:0] o);
        logic [12:0] exp [4];
        exp = '{O_GETB, O_EXEC_MOV, O_WREG, O_WAIT};
        launch(oc, o);
        n_checks++;
        if (outs() !== O_DEC) $display("FAIL %s_decode outputs=%h expected=%h", name, outs(), O_DEC);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) begin opcode = 3'b110; op = 2'b10; end
            n_checks++;
            if (outs() !== exp[i]) $display("FAIL %s_cycle%0d outputs=%h expected=%h", name, i + 2, outs(), exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_illegal(input string name, input logic [2:0] oc, input logic [1:0] o);
        launch(oc, o);
        n_checks++;
        if (outs() !== O_DEC) $display("FAIL %s_decode outputs=%h expected=%h", name, outs(), O_DEC);
        else n_pass++;
        tick();
        n_checks++;
        if (outs() !== O_WAIT) $display("FAIL %s_return outputs=%h expected=%h", name, outs(), O_WAIT);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        launch(3'b101, 2'b00);
        tick();
        tick();
        n_checks++;
        if (outs() !== O_GETB) $display("FAIL abort_getb outputs=%h expected=%h", outs(), O_GETB);
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (outs() !== O_WAIT) $display("FAIL abort_async outputs=%h expected=%h", outs(), O_WAIT);
        else n_pass++;
        tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if (outs() !== O_WAIT) $display("FAIL abort_no_write outputs=%h expected=%h", outs(), O_WAIT);
        else n_pass++;
        test_mov_imm("post_reset_mov");
    endtask

    // s held high through an ADD: no restart until WAIT, then the next DECODE follows immediately
    task automatic test_back_to_back();
        logic [12:0] exp [5];
        exp = '{O_GETA, O_GETB, O_EXEC_ALU, O_WREG, O_WAIT};
        opcode = 3'b101; op = 2'b00; s = 1'b1;
        tick();
        n_checks++;
        if (outs() !== O_DEC) $display("FAIL held_decode outputs=%h expected=%h", outs(), O_DEC);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (outs() !== exp[i]) $display("FAIL held_cycle%0d outputs=%h expected=%h", i + 2, outs(), exp[i]);
            else n_pass++;
        end
        opcode = 3'b111;
        tick();
        n_checks++;
        if (outs() !== O_DEC) $display("FAIL held_restart outputs=%h expected=%h", outs(), O_DEC);
        else n_pass++;
        s = 1'b0;
        tick();
        n_checks++;
        if (outs() !== O_WAIT) $display("FAIL held_illegal_return outputs=%h expected=%h", outs(), O_WAIT);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_mov_imm("mov_imm");
        test_alu("add", 2'b00);
        test_alu("and", 2'b10);
        test_cmp();
        test_single("mvn", 3'b101, 2'b11);
        test_single("mov_reg", 3'b110, 2'b00);
        test_illegal("illegal_111", 3'b111, 2'b00);
        test_illegal("illegal_110_01", 3'b110, 2'b01);
        test_illegal("illegal_100_11", 3'b100, 2'b11);
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
